alarm_sequencer: RTL and testbench
==================================

ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000, clk cycles per second (1 kHz system clock).
REQ-002 SHALL have parameter RING_TIMEOUT_S, default 60, seconds of unanswered ringing before auto-snooze.
REQ-003 SHALL have parameter SNOOZE_S, default 300, snooze length in seconds.
REQ-004 SHALL have parameter MAX_SNOOZE, default 3, snoozes allowed before the game is mandatory (1..3).
REQ-005 SHALL have parameter COOLDOWN_S, default 60, post-dismiss lockout in seconds.
REQ-006 clk  input  1  system clock; one clock domain only.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 alarm_enable  input  1  level; alarm armed when high.
REQ-009 match  input  1  one-cycle pulse: real time equals alarm time.
REQ-010 snooze_btn  input  1  debounced level; acted on at rising edge only.
REQ-011 game_done  input  1  one-cycle pulse: wack-a-mole score threshold reached.
REQ-012 ring  output  1  drives alarm ringer/flash.
REQ-013 game_start  output  1  one-cycle pulse starting the wack-a-mole state machine.
REQ-014 snooze_active  output  1  high while in SNOOZE.
REQ-015 snooze_count  output  2  snoozes used this alarm event.
REQ-016 state  output  3  current state encoding, for debug/display.

Function
REQ-017 States SHALL be IDLE=0, RING=1, SNOOZE=2, GAME=3, COOLDOWN=4; all outputs registered.
REQ-018 IDLE: match with alarm_enable high -> RING; ring=1 on the cycle after the match pulse.
REQ-019 RING: snooze_btn rising edge with snooze_count<MAX_SNOOZE -> SNOOZE, snooze_count+1.
REQ-020 RING: snooze_btn rising edge with snooze_count==MAX_SNOOZE -> GAME, game_start pulsed one cycle on entry.
REQ-021 RING: RING_TIMEOUT_S elapsed, no press -> SNOOZE with count+1 if count<MAX_SNOOZE, else stay in RING (timer restarts).
REQ-022 RING: press and timeout in same cycle -> press rule applies.
REQ-023 SNOOZE: ring=0; after SNOOZE_S elapsed -> RING; snooze_btn ignored.
REQ-024 GAME: ring=1; game_done -> COOLDOWN, ring=0 next cycle; no timeout.
REQ-025 COOLDOWN: after COOLDOWN_S elapsed -> IDLE, snooze_count cleared; match ignored throughout.
REQ-026 match ignored in all states except IDLE; game_done ignored except in GAME.
REQ-027 alarm_enable low in any state SHALL force IDLE next cycle, clear snooze_count and timer, ring=0; dominates all other events.
REQ-028 Duration N seconds SHALL expire exactly N*TICK_DIV cycles after state entry; prescaler and second counter restart on every state entry.
REQ-029 snooze_count SHALL saturate at MAX_SNOOZE, never wrap.
REQ-030 Edge detector on snooze_btn SHALL be registered; button held through entry into RING does not count as a press.

Reset
REQ-031 reset SHALL asynchronously set state=IDLE, ring=0, game_start=0, snooze_active=0, snooze_count=0, prescaler and timer=0, edge-detect register=1.
REQ-032 Deassertion SHALL take effect at the next clk edge; reset mid-RING/GAME silences immediately.

Structure
REQ-033 Package alarm_seq_pkg SHALL hold state encodings and parameter defaults.
REQ-034 One sub-module sec_timer SHALL implement prescaler plus loadable seconds down-counter with one-cycle expire output.
REQ-035 Timer widths SHALL be sized from parameters (clog2), no truncation at defaults.

Verification (TICK_DIV=10, RING_TIMEOUT_S=2, SNOOZE_S=3, MAX_SNOOZE=2, COOLDOWN_S=2)
REQ-036 match pulse in IDLE -> ring=1 next cycle, state=1; press at cycle 5 -> state=2, snooze_count=1, ring=0; ring=1 again 30 cycles later.
REQ-037 No press -> auto-snooze after 20 cycles twice (count=2), then ring persists past 20 cycles in RING; press -> state=3, game_start one-cycle pulse.
REQ-038 GAME, game_done pulse -> ring=0 next cycle, state=4; match during COOLDOWN ignored; IDLE after 20 cycles, snooze_count=0.
REQ-039 alarm_enable dropped in SNOOZE and in GAME -> state=0, count=0 next cycle; press and timeout same cycle in RING with count=2 -> GAME.
REQ-040 reset asserted mid-RING without clk edge -> ring=0 immediately; snooze_btn held high across match -> no snooze until released and re-pressed.

Source files
------------

// File: rtl/alarm_seq_pkg.sv
// alarm_seq_pkg
// Shared definitions for the alarm sequencer: the state encoding, the
// parameter defaults and a small helper used to size the seconds timer.
// No ports; imported by alarm_sequencer and sec_timer.
package alarm_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RING     = 3'd1,
        S_SNOOZE   = 3'd2,
        S_GAME     = 3'd3,
        S_COOLDOWN = 3'd4
    } state_t;

    localparam int DEF_TICK_DIV       = 1000;
    localparam int DEF_RING_TIMEOUT_S = 60;
    localparam int DEF_SNOOZE_S       = 300;
    localparam int DEF_MAX_SNOOZE     = 3;
    localparam int DEF_COOLDOWN_S     = 60;

    // Largest of three durations; the seconds counter must hold it.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/alarm_sequencer_if.sv
// alarm_sequencer_if
// Groups the alarm sequencer's event inputs and status outputs.
//   alarm_enable, match, snooze_btn, game_done : driven by the environment
//   ring, game_start, snooze_active,
//   snooze_count[1:0], state[2:0]              : driven by the sequencer
// slave  = the sequencer's view, master = the environment's view.
interface alarm_sequencer_if;
    logic       alarm_enable;
    logic       match;
    logic       snooze_btn;
    logic       game_done;
    logic       ring;
    logic       game_start;
    logic       snooze_active;
    logic [1:0] snooze_count;
    logic [2:0] state;

    modport slave (
        input  alarm_enable, match, snooze_btn, game_done,
        output ring, game_start, snooze_active, snooze_count, state
    );

    modport master (
        output alarm_enable, match, snooze_btn, game_done,
        input  ring, game_start, snooze_active, snooze_count, state
    );
endinterface

// File: rtl/alarm_sequencer_sec_timer.sv
// sec_timer
// Prescaler plus loadable seconds down-counter. Loading N makes o_expire
// high for exactly one cycle, so that a state change taken on that cycle
// lands N*TICK_DIV clock edges after the load edge.
//   clk, reset : clock, async active-high reset
//   i_load     : restart prescaler and load i_secs (0 = timer idle)
//   i_secs     : duration in seconds
//   o_expire   : one-cycle pulse in the last cycle of the duration
module sec_timer #(
    parameter int TICK_DIV = alarm_seq_pkg::DEF_TICK_DIV,
    parameter int MAX_S    = alarm_seq_pkg::DEF_SNOOZE_S,
    parameter int SEC_W    = $clog2(MAX_S + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [SEC_W-1:0] i_secs,
    output logic             o_expire
);
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] r_pre;
    logic [SEC_W-1:0] r_sec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre <= '0;
            r_sec <= '0;
        end else if (i_load) begin
            r_pre <= '0;
            r_sec <= i_secs;
        end else if (r_sec != '0) begin
            // Counter parks at zero so an idle timer never fires.
            if (r_pre == PRE_LAST) begin
                r_pre <= '0;
                r_sec <= r_sec - SEC_W'(1);
            end else begin
                r_pre <= r_pre + PRE_W'(1);
            end
        end
    end

    assign o_expire = (r_sec == SEC_W'(1)) && (r_pre == PRE_LAST);

endmodule

// File: rtl/alarm_sequencer.sv
// alarm_sequencer
// Alarm event controller: rings on a time match, allows a limited number
// of snoozes (manual or auto after an unanswered ring), then demands the
// wack-a-mole game, then locks out new alarms for a cooldown period.
//   clk, reset : clock, async active-high reset
//   bus        : alarm_sequencer_if.slave (enable/match/button/game_done in,
//                ring/game_start/snooze_active/snooze_count/state out)
// All outputs are registered from the next-state decode.
module alarm_sequencer
    import alarm_seq_pkg::*;
#(
    parameter int TICK_DIV       = DEF_TICK_DIV,
    parameter int RING_TIMEOUT_S = DEF_RING_TIMEOUT_S,
    parameter int SNOOZE_S       = DEF_SNOOZE_S,
    parameter int MAX_SNOOZE     = DEF_MAX_SNOOZE,
    parameter int COOLDOWN_S     = DEF_COOLDOWN_S
) (
    input logic               clk,
    input logic               reset,
    alarm_sequencer_if.slave  bus
);
    localparam int MAX_S = max3(RING_TIMEOUT_S, SNOOZE_S, COOLDOWN_S);
    localparam int SEC_W = $clog2(MAX_S + 1);
    localparam logic [1:0] MAX_CNT = 2'(MAX_SNOOZE);

    state_t           r_state;
    logic [1:0]       r_cnt;
    logic             r_ring;
    logic             r_game_start;
    logic             r_snooze_act;
    logic             r_btn_q;

    state_t           w_nxt;
    logic [1:0]       w_nxt_cnt;
    logic             w_restart;
    logic             w_game_start;
    logic [SEC_W-1:0] w_secs;
    logic             w_press;
    logic             w_expire;

    // Reset value of r_btn_q is 1, so a button already held never
    // produces an edge until it has been released.
    assign w_press = bus.snooze_btn & ~r_btn_q;

    always_comb begin
        w_nxt        = r_state;
        w_nxt_cnt    = r_cnt;
        w_restart    = 1'b0;
        w_game_start = 1'b0;
        if (!bus.alarm_enable) begin
            w_nxt     = S_IDLE;
            w_nxt_cnt = 2'd0;
            w_restart = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.match) w_nxt = S_RING;
                end
                S_RING: begin
                    // A press takes priority over a simultaneous timeout.
                    if (w_press) begin
                        if (r_cnt < MAX_CNT) begin
                            w_nxt     = S_SNOOZE;
                            w_nxt_cnt = r_cnt + 2'd1;
                        end else begin
                            w_nxt        = S_GAME;
                            w_game_start = 1'b1;
                        end
                    end else if (w_expire) begin
                        if (r_cnt < MAX_CNT) begin
                            w_nxt     = S_SNOOZE;
                            w_nxt_cnt = r_cnt + 2'd1;
                        end else begin
                            w_restart = 1'b1;   // keep ringing, new period
                        end
                    end
                end
                S_SNOOZE: begin
                    if (w_expire) w_nxt = S_RING;
                end
                S_GAME: begin
                    if (bus.game_done) w_nxt = S_COOLDOWN;
                end
                S_COOLDOWN: begin
                    if (w_expire) begin
                        w_nxt     = S_IDLE;
                        w_nxt_cnt = 2'd0;
                    end
                end
                default: begin
                    w_nxt     = S_IDLE;
                    w_nxt_cnt = 2'd0;
                end
            endcase
        end
        if (w_nxt != r_state) w_restart = 1'b1;

        case (w_nxt)
            S_RING:     w_secs = SEC_W'(RING_TIMEOUT_S);
            S_SNOOZE:   w_secs = SEC_W'(SNOOZE_S);
            S_COOLDOWN: w_secs = SEC_W'(COOLDOWN_S);
            default:    w_secs = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 2'd0;
            r_ring       <= 1'b0;
            r_game_start <= 1'b0;
            r_snooze_act <= 1'b0;
            r_btn_q      <= 1'b1;
        end else begin
            r_state      <= w_nxt;
            r_cnt        <= w_nxt_cnt;
            r_ring       <= (w_nxt == S_RING) || (w_nxt == S_GAME);
            r_game_start <= w_game_start;
            r_snooze_act <= (w_nxt == S_SNOOZE);
            r_btn_q      <= bus.snooze_btn;
        end
    end

    sec_timer #(
        .TICK_DIV (TICK_DIV),
        .MAX_S    (MAX_S),
        .SEC_W    (SEC_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_restart),
        .i_secs   (w_secs),
        .o_expire (w_expire)
    );

    assign bus.ring          = r_ring;
    assign bus.game_start    = r_game_start;
    assign bus.snooze_active = r_snooze_act;
    assign bus.snooze_count  = r_cnt;
    assign bus.state         = r_state;

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer
// Directed stimulus with hand-computed expectations. The stimulus process
// queues (cycle, field, value) entries; the monitor compares every entry
// whose cycle has arrived, one time unit after each rising clock edge.
module tb_alarm_sequencer;

    localparam int F_ST = 0, F_RING = 1, F_GS = 2, F_SA = 3, F_CNT = 4;
    localparam int IDLE = 0, RING = 1, SNOOZE = 2, GAME = 3, COOL = 4;

    typedef struct {
        int    cyc;
        int    fld;
        int    val;
        string nm;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    alarm_sequencer_if bus ();

    alarm_sequencer #(
        .TICK_DIV       (10),
        .RING_TIMEOUT_S (2),
        .SNOOZE_S       (3),
        .MAX_SNOOZE     (2),
        .COOLDOWN_S     (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic int field(input int f);
        case (f)
            F_ST:    return int'(bus.state);
            F_RING:  return int'(bus.ring);
            F_GS:    return int'(bus.game_start);
            F_SA:    return int'(bus.snooze_active);
            default: return int'(bus.snooze_count);
        endcase
    endfunction

    // Monitor
    always begin
        @(posedge clk);
        cyc++;
        #1;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc <= cyc) begin
                checks++;
                if (q[i].cyc < cyc || field(q[i].fld) != q[i].val) begin
                    errors++;
                    $display("FAIL %s @cyc %0d: got %0d want %0d (due cyc %0d)",
                             q[i].nm, cyc, field(q[i].fld), q[i].val, q[i].cyc);
                end
                q.delete(i);
            end
        end
    end

    task automatic exp1(input int k, input int f, input int v, input string nm);
        exp_t e;
        e.cyc = cyc + k; e.fld = f; e.val = v; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic exp_all(input int k, input int st, input int rg, input int gs,
                           input int sa, input int cnt, input string nm);
        exp1(k, F_ST,   st,  {nm, ".state"});
        exp1(k, F_RING, rg,  {nm, ".ring"});
        exp1(k, F_GS,   gs,  {nm, ".game_start"});
        exp1(k, F_SA,   sa,  {nm, ".snooze_active"});
        exp1(k, F_CNT,  cnt, {nm, ".snooze_count"});
    endtask

    task automatic chk_now(input string nm, input int f, input int v);
        checks++;
        if (field(f) != v) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, field(f), v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_match();
        bus.match = 1'b1; step(1); bus.match = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.alarm_enable = 1'b0;
        bus.match = 1'b0;
        bus.snooze_btn = 1'b0;
        bus.game_done = 1'b0;
        step(3);
        chk_now("reset.state", F_ST, IDLE);
        chk_now("reset.ring", F_RING, 0);
        chk_now("reset.count", F_CNT, 0);
        reset = 1'b0;
        bus.alarm_enable = 1'b1;
        exp_all(1, IDLE, 0, 0, 0, 0, "idle");
        step(2);

        // Disabled alarm ignores match; game_done ignored in IDLE
        bus.alarm_enable = 1'b0;
        exp1(1, F_ST, IDLE, "en_low_match");
        pulse_match();
        bus.alarm_enable = 1'b1;
        step(1);
        bus.game_done = 1'b1;
        exp1(1, F_ST, IDLE, "done_in_idle");
        step(1); bus.game_done = 1'b0; step(1);

        // Ring, manual snooze, ring returns 30 cycles after snooze entry
        exp_all(1, RING, 1, 0, 0, 0, "ring_entry");
        pulse_match();
        step(3);
        bus.snooze_btn = 1'b1;
        exp_all(1, SNOOZE, 0, 0, 1, 1, "press_snooze");
        exp1(30, F_ST, SNOOZE, "snooze_hold");
        exp_all(31, RING, 1, 0, 0, 1, "snooze_end");
        step(3); bus.snooze_btn = 1'b0;
        step(5); bus.snooze_btn = 1'b1;   // ignored in SNOOZE
        step(2); bus.snooze_btn = 1'b0;
        step(21);

        // Auto-snooze to count 2, then ringing persists across timeouts
        exp1(19, F_ST, RING, "ring_pre_timeout");
        exp_all(20, SNOOZE, 0, 0, 1, 2, "auto_snooze2");
        exp1(49, F_ST, SNOOZE, "snooze2_hold");
        exp_all(50, RING, 1, 0, 0, 2, "snooze2_end");
        exp1(70, F_ST, RING, "sat_timeout");
        exp1(70, F_CNT, 2, "cnt_saturated");
        exp1(71, F_RING, 1, "sat_ring_on");
        exp1(91, F_ST, RING, "sat_timeout2");
        step(95);
        bus.snooze_btn = 1'b1;
        exp_all(1, GAME, 1, 1, 0, 2, "press_game");
        exp1(2, F_GS, 0, "game_start_pulse");
        exp1(2, F_ST, GAME, "game_hold");
        step(1); bus.snooze_btn = 1'b0;

        // GAME has no timeout; game_done -> COOLDOWN, match ignored there
        exp1(40, F_ST, GAME, "game_no_timeout");
        step(40);
        bus.game_done = 1'b1;
        exp_all(1, COOL, 0, 0, 0, 2, "done_cooldown");
        step(1); bus.game_done = 1'b0;
        step(4);
        exp1(1, F_ST, COOL, "cool_match_ignored");
        pulse_match();
        exp1(14, F_ST, COOL, "cool_hold");
        exp_all(15, IDLE, 0, 0, 0, 0, "cool_end");
        step(16);

        // Enable dropped in SNOOZE
        exp1(1, F_ST, RING, "ring2_entry");
        pulse_match();
        step(2);
        bus.snooze_btn = 1'b1;
        exp1(1, F_ST, SNOOZE, "snooze_pre_drop");
        step(1); bus.snooze_btn = 1'b0;
        step(3);
        bus.alarm_enable = 1'b0;
        exp_all(1, IDLE, 0, 0, 0, 0, "en_drop_snooze");
        step(1); bus.alarm_enable = 1'b1; step(1);

        // Enable dropped in GAME
        pulse_match();
        step(1);
        bus.snooze_btn = 1'b1;
        exp1(1, F_CNT, 1, "g_snooze1");
        exp1(31, F_ST, RING, "g_ring2");
        step(1); bus.snooze_btn = 1'b0;
        step(30); step(2);
        bus.snooze_btn = 1'b1;
        exp1(1, F_CNT, 2, "g_snooze2");
        step(1); bus.snooze_btn = 1'b0;
        step(30); step(2);
        bus.snooze_btn = 1'b1;
        exp1(1, F_ST, GAME, "g_game");
        step(1); bus.snooze_btn = 1'b0;
        step(3);
        bus.alarm_enable = 1'b0;
        exp_all(1, IDLE, 0, 0, 0, 0, "en_drop_game");
        step(1); bus.alarm_enable = 1'b1; step(1);

        // Press and timeout in the same cycle with count at max -> GAME
        pulse_match();
        exp1(100, F_ST, RING, "pt_ring");
        exp1(100, F_CNT, 2, "pt_cnt");
        step(119);
        bus.snooze_btn = 1'b1;
        exp_all(1, GAME, 1, 1, 0, 2, "press_and_timeout");
        step(1); bus.snooze_btn = 1'b0;
        bus.alarm_enable = 1'b0;
        exp1(1, F_ST, IDLE, "pt_exit");
        step(1); bus.alarm_enable = 1'b1; step(1);

        // Button held across match does not snooze until re-pressed
        bus.snooze_btn = 1'b1;
        step(2);
        pulse_match();
        exp1(5, F_ST, RING, "held_btn_ring");
        exp1(5, F_SA, 0, "held_btn_no_snooze");
        step(5);
        bus.snooze_btn = 1'b0;
        step(1);
        bus.snooze_btn = 1'b1;
        exp_all(1, SNOOZE, 0, 0, 1, 1, "repress");
        step(1); bus.snooze_btn = 1'b0;
        exp1(30, F_ST, RING, "pre_reset_ring");
        step(32);

        // Async reset mid-RING silences without a clock edge
        #2 reset = 1'b1;
        #1;
        chk_now("async_rst.ring", F_RING, 0);
        chk_now("async_rst.state", F_ST, IDLE);
        chk_now("async_rst.count", F_CNT, 0);
        step(1);
        reset = 1'b0;
        exp_all(1, IDLE, 0, 0, 0, 0, "post_reset");
        step(3);

        for (int i = 0; i < 200 && q.size() != 0; i++) step(1);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations never reached", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
